// File: rtl/rf_pkg.sv
// Shared defaults for the integer register file and its hazard scoreboard.
package rf_pkg;
    localparam int RF_XLEN     = 32;
    localparam int RF_NUM_REGS = 32;
    localparam int ZERO_REG    = 0;
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-writeback flags: writeback clears, decode reserve sets.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    output logic [NUM_REGS-1:0] busy
);
    logic [NUM_REGS-1:0] r_busy;
    logic                w_clr;
    logic                w_set;

    assign w_clr = we && (waddr != AW'(ZERO_REG));
    assign w_set = rsv_en && (rsv_addr != AW'(ZERO_REG));

    // Set is applied after clear so a reserve on the same edge as the
    // writeback leaves the register pending for the newer producer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            if (w_clr) r_busy[waddr] <= 1'b0;
            if (w_set) r_busy[rsv_addr] <= 1'b1;
        end
    end

    assign busy = r_busy;
endmodule

// File: rtl/reg_file_sb.sv
// Integer register file with zero register, write-to-read bypass, busy
// scoreboard for decode stalls, ALU B-operand mux and store-data output.
module reg_file_sb
    import rf_pkg::*;
#(
    parameter int XLEN     = RF_XLEN,
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int AW       = $clog2(NUM_REGS),
    parameter int NUM_RD   = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_RD*AW-1:0]   rd_addr,
    output logic [NUM_RD*XLEN-1:0] rd_data,
    output logic [NUM_RD-1:0]      rd_busy,
    input  logic                   alu_src,
    input  logic [XLEN-1:0]        imm,
    output logic [XLEN-1:0]        alu_b,
    output logic [XLEN-1:0]        mem_wdata,
    input  logic                   we,
    input  logic [AW-1:0]          waddr,
    input  logic [XLEN-1:0]        wdata,
    input  logic                   rsv_en,
    input  logic [AW-1:0]          rsv_addr,
    output logic                   stall
);
    logic [XLEN-1:0]     r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] w_busy;
    logic                w_wr_en;
    logic                w_byp_en;
    logic [XLEN-1:0]     w_rs2;

    assign w_wr_en  = we && (waddr != AW'(ZERO_REG));
    // While reset is held the write is dropped, so it must not be bypassed either.
    assign w_byp_en = we && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (w_wr_en) begin
            r_regs[waddr] <= wdata;
        end
    end

    rf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .AW       (AW)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .waddr    (waddr),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .busy     (w_busy)
    );

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0] w_a;
        logic          w_zero;
        logic          w_hit;

        assign w_a    = rd_addr[p*AW +: AW];
        assign w_zero = (w_a == AW'(ZERO_REG));
        assign w_hit  = w_byp_en && (waddr == w_a);

        assign rd_data[p*XLEN +: XLEN] = w_zero ? '0 : (w_hit ? wdata : r_regs[w_a]);
        assign rd_busy[p]              = !w_zero && !w_hit && w_busy[w_a];
    end

    assign w_rs2     = rd_data[XLEN +: XLEN];
    assign mem_wdata = w_rs2;
    assign alu_b     = alu_src ? imm : w_rs2;
    assign stall     = rd_busy[0] | rd_busy[1];
endmodule
